demux_nway_stream: RTL

- Parametrised, registered successor to the 4-way demultiplexer.
- Routes a WIDTH-bit word from one input stream to one of WAYS output channels, chosen by select, or to all channels in broadcast mode.
- Each output channel has a one-entry holding register with a valid/ready handshake, so slow consumers back-pressure the producer without losing data.
- Sits between the datapath producer and per-unit consumers in the compute fabric.

---
 rtl/demux_nway_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/demux_nway_stream.sv
// -----------------------------------------------------------------------------
// demux_nway_stream
//
// Registered N-way stream demultiplexer. A WIDTH-bit word arriving on the
// input handshake goes to the channel named by `select`, or to every channel
// when `broadcast` is high. Each output channel has a one-entry holding
// register with its own valid/ready handshake. A slow consumer therefore
// back-pressures the producer without losing data.
//
// Parameters
//   WIDTH      data word width in bits (>= 1)
//   WAYS       number of output channels (>= 2)
//   SEL_WIDTH  select width, 2**SEL_WIDTH >= WAYS
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   in         input data word
//   select     destination channel index
//   broadcast  deliver the word to every channel; select is ignored
//   in_valid   producer presents a word
//   in_ready   block accepts the word this cycle (combinational, independent
//              of in_valid)
//   out        channel k data at bits [k*WIDTH +: WIDTH]; reads 0 when idle
//   out_valid  channel k holds an undelivered word
//   out_ready  consumer k takes its word this cycle
//   sel_err    sticky: a word was accepted with an out-of-range select
// -----------------------------------------------------------------------------
module demux_nway_stream #(
  parameter int WIDTH     = 16,
  parameter int WAYS      = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic [SEL_WIDTH-1:0]  select,
  input  logic                  broadcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WAYS*WIDTH-1:0] out,
  output logic [WAYS-1:0]       out_valid,
  input  logic [WAYS-1:0]       out_ready,
  output logic                  sel_err
);

  if ((2 ** SEL_WIDTH) < WAYS) begin : g_sel_width_check
    $error("demux_nway_stream: SEL_WIDTH too narrow to address WAYS channels");
  end

  if (WAYS < 2) begin : g_ways_check
    $error("demux_nway_stream: WAYS must be at least 2");
  end

  if (WIDTH < 1) begin : g_width_check
    $error("demux_nway_stream: WIDTH must be at least 1");
  end

  logic [WAYS-1:0][WIDTH-1:0] data_q, data_d;
  logic [WAYS-1:0]            vld_q, vld_d;
  logic                       sel_err_q, sel_err_d;

  logic [WAYS-1:0] free;    // channel can take a word at the coming edge
  logic [WAYS-1:0] tgt;     // channels addressed by the current request
  logic [WAYS-1:0] load;
  logic [WAYS-1:0] drain;
  logic            in_range;
  logic            accept;

  // Request decode and handshake
  always_comb begin
    in_range = (int'(select) < WAYS);
    for (int k = 0; k < WAYS; k++) begin
      tgt[k] = broadcast || (int'(select) == k);
    end

    // A channel drained this cycle can be refilled on the same edge.
    free = ~vld_q | out_ready;

    // Broadcast waits until every channel is free at once, so it never
    // lands partially. An out-of-range select is swallowed immediately.
    if (broadcast) begin
      in_ready = &free;
    end else if (in_range) begin
      in_ready = |(tgt & free);
    end else begin
      in_ready = 1'b1;
    end

    accept = in_valid && in_ready;
    load   = {WAYS{accept}} & tgt;
    drain  = vld_q & out_ready;
  end

  // Per-channel next state
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    for (int k = 0; k < WAYS; k++) begin
      if (load[k]) begin
        data_d[k] = in;
        vld_d[k]  = 1'b1;
      end else if (drain[k]) begin
        // Idle channels present zero rather than stale data.
        data_d[k] = '0;
        vld_d[k]  = 1'b0;
      end
    end
    sel_err_d = sel_err_q || (accept && !broadcast && !in_range);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      vld_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      vld_q     <= vld_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out       = data_q;
  assign out_valid = vld_q;
  assign sel_err   = sel_err_q;

endmodule
